add_sequencer: RTL

Multi-precision add/subtract sequencer that time-shares one 8-bit ripple-carry adder slice across the bytes of a wide operand. A requester hands over two NBYTES-wide operands with a valid/ready handshake. The block feeds them to the slice one byte per cycle, least significant byte first, and chains the carry through a register. The full-width result and flags are returned on a second valid/ready handshake. It sits between the compute control logic and the existing 8-bit adder datapath.

---
 rtl/add_sequencer_pkg.sv | 18 +
 rtl/add_sequencer_byte_adder_cin.sv | 23 ++
 rtl/add_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/add_sequencer_pkg.sv
// Shared types and constants for the byte-serial multi-precision add/subtract sequencer.
package add_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Byte index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nbytes);
    return (nbytes <= 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/add_sequencer_byte_adder_cin.sv
// 8-bit ripple-carry adder slice with carry in, one full-adder cell per bit.
module byte_adder_cin (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end

endmodule

// File: rtl/add_sequencer.sv
// Multi-precision add/subtract: one 8-bit slice time-shared over NBYTES bytes, LSB first,
// carry chained through a register; result returned on a valid/ready handshake.
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                op_sub,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                overflow,
  output logic                zero
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = idx_width(NBYTES);

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic           sub_q, sub_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic           start_ready_q, start_ready_d, res_valid_q, res_valid_d;

  logic [7:0]     slice_a, slice_b, slice_sum;
  logic           slice_cout, last_byte;

  // Select the current byte pair; B is inverted for subtraction.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int k = 0; k < int'(NBYTES); k++) begin
      if (idx_q == IW'(k)) begin
        slice_a = a_q[8*k +: 8];
        slice_b = (sub_q == OP_ADD) ? b_q[8*k +: 8] : ~b_q[8*k +: 8];
      end
    end
    last_byte = (idx_q == IW'(NBYTES - 1));
  end

  byte_adder_cin u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          a_d     = a;
          b_d     = b;
          sub_d   = op_sub;
          idx_d   = '0;
          carry_d = (op_sub == OP_SUB);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < int'(NBYTES); k++) begin
          if (idx_q == IW'(k)) sum_d[8*k +: 8] = slice_sum;
        end
        carry_d = slice_cout;
        if (last_byte) begin
          cout_d  = slice_cout;
          ovf_d   = (slice_a[7] == slice_b[7]) && (slice_sum[7] != slice_a[7]);
          zero_d  = (sum_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    start_ready_d = (state_d == ST_IDLE);
    res_valid_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sub_q         <= 1'b0;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      sum_q         <= '0;
      cout_q        <= 1'b0;
      ovf_q         <= 1'b0;
      zero_q        <= 1'b0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sub_q         <= sub_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      sum_q         <= sum_d;
      cout_q        <= cout_d;
      ovf_q         <= ovf_d;
      zero_q        <= zero_d;
      start_ready_q <= start_ready_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign start_ready = start_ready_q;
  assign res_valid   = res_valid_q;
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign zero        = zero_q;

endmodule
